// File: rtl/uart_frame_tx.sv
// uart_frame_tx: multi-byte UART transmitter, byte 0 first; define UART_TX_PARITY_EN to add a parity bit per byte
module uart_frame_tx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int NUM_BYTES  = 50,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] data_in,
    input  logic                   send,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);
    localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(DIVISOR);
    localparam int BW = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIVISOR - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic PAR_SENSE = PARITY_ODD[0];
`endif
    logic [2:0]             state;
    logic [CW-1:0]          baud_cnt;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic [BW-1:0]          byte_idx;
    logic [8*NUM_BYTES-1:0] shreg;
    logic [7:0]             cur_byte;
    logic                   tick;
    // the byte on the wire always sits in the low 8 bits; bits are picked by index rather than shifted
    assign cur_byte = shreg[7:0];
    assign tick = (baud_cnt == DIV_LAST);
`ifdef UART_TX_PARITY_EN
    logic parity;
    assign parity = ^cur_byte ^ PAR_SENSE;
`endif
    // frame sequencer: line changes only when the baud counter wraps, so every bit lasts DIVISOR cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            byte_idx <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                baud_cnt <= '0;
                if (send) begin
                    shreg    <= data_in;
                    byte_idx <= '0;
                    bit_cnt  <= '0;
                    stop_cnt <= 1'b0;
                    busy     <= 1'b1;
                    tx       <= 1'b0;
                    state    <= START;
                end
            end else begin
                baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
                if (tick) begin
                    case (state)
                        START: begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            tx      <= cur_byte[0];
                        end
                        DATA: begin
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx      <= cur_byte[bit_cnt + 3'd1];
                            end else begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= parity;
`else
                                state    <= STOP;
                                stop_cnt <= 1'b0;
                                tx       <= 1'b1;
`endif
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                            tx       <= 1'b1;
                        end
`endif
                        STOP: begin
                            if (stop_cnt != STOP_LAST) begin
                                stop_cnt <= 1'b1;
                            end else if (byte_idx < BYTE_LAST) begin
                                shreg    <= shreg >> 8;
                                byte_idx <= byte_idx + 1'b1;
                                state    <= START;
                                tx       <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

- Parametrised UART transmitter that serialises a multi-byte result word, byte 0 (`data_in[7:0]`) first.
- Sits between the matrix-multiply pipeline output and the board TX pin, replacing the fixed-width transmitter.
- Generalises payload size, baud divisor and stop-bit count, adds a completion pulse, and optionally adds a parity bit.
- Guarantees exact bit periods and no gaps between bytes.

## Interface
- `CLOCK_FREQ`, 100_000_000, clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate; `DIVISOR = CLOCK_FREQ / BAUD_RATE` (integer division), must be ≥ 2.
- `NUM_BYTES`, 50, payload bytes per transfer, ≥ 1.
- `STOP_BITS`, 1, stop bits per byte; legal values are 1 or 2.
- `PARITY_ODD`, 0, parity sense (0 = even, 1 = odd); only used when `UART_TX_PARITY_EN` is defined.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  8*NUM_BYTES  payload, captured on acceptance.
- `send`  in  1  transfer request.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high from acceptance until completion.
- `done`  out  1  one-cycle pulse when the final stop bit ends.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0. Reset is asynchronous and also aborts a transfer mid-frame; the line returns high immediately.
- **Acceptance:** `send`=1 while `busy`=0, sampled at a rising edge. `data_in` is copied into an internal shift register. `send` while `busy`=1 is ignored, and changes to `data_in` after acceptance have no effect.
- **States:** IDLE → START → DATA → [PARITY] → STOP → (START of the next byte | IDLE).
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: 8 bits, LSB first; the bit counter runs 0..7.
  - PARITY: `tx` = XOR of the 8 data bits, XORed with `PARITY_ODD`.
  - STOP: `tx`=1 for `STOP_BITS` bit periods.
- **Byte advance:** after the STOP period, if `byte_idx < NUM_BYTES-1`, the shift register moves right by 8, `byte_idx` increments, and START follows with no idle gap. Otherwise the FSM returns to IDLE.
- **Counter widths:** baud counter is `$clog2(DIVISOR)` bits and runs 0..DIVISOR-1. `byte_idx` is `$clog2(NUM_BYTES)` bits, with a minimum of 1.

## Timing
- **Start of transfer:** on the acceptance edge, `busy`←1, `tx`←0 and START begins. The start bit appears on the line one cycle after `send` is sampled.
- **Bit period:** every bit holds `tx` for exactly DIVISOR cycles. Transitions occur only on the edge where the baud counter wraps from DIVISOR-1 to 0.
- **Bits per byte:** `B = 9 + P + STOP_BITS`, where P = 1 if parity is enabled, else 0.
- **Transfer length:** the time from `tx` falling to `done` is exactly `NUM_BYTES*B*DIVISOR` cycles.
- **Completion edge:** on the edge ending the last stop bit, `done`←1 for one cycle, `busy`←0 and the state becomes IDLE. `tx` stays 1.
- **Back-to-back transfers:** `send` sampled on the cycle `done`=1 is accepted, because `busy` is already 0 then. With `send` held high, consecutive transfers are separated by exactly 1 idle cycle.
- **Single byte:** `NUM_BYTES`=1 is legal. STOP goes directly to IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is present and each byte is 11 bits (1 stop bit) or 12 bits (2 stop bits).
  - `PARITY_ODD` selects the sense.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic are generated; DATA goes directly to STOP.
  - Each byte is 10 or 11 bits.
  - `PARITY_ODD` is ignored.

## Test plan
Common setup for all scenarios: `CLOCK_FREQ`=1_000_000 and `BAUD_RATE`=250_000, giving DIVISOR=4.

1. **Basic frame:** `NUM_BYTES`=2, no parity, `data_in`=16'hA55A, pulse `send`.
   - Line sampled mid-bit reads 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1.
   - `done` pulses 80 cycles after `tx` falls; `busy` drops on that same edge.
2. **Even parity:** `UART_TX_PARITY_EN` defined, `PARITY_ODD`=0, `NUM_BYTES`=1, `data_in`=8'h01.
   - Parity bit = 1; frame is 0,1,0,0,0,0,0,0,0,1,1; `done` at 44 cycles.
   - Repeat with `PARITY_ODD`=1: parity bit = 0.
3. **Two stop bits:** `STOP_BITS`=2, `NUM_BYTES`=2, `data_in`=16'hFF00.
   - `tx` stays high for 8 cycles between the bytes; `done` at 88 cycles.
4. **Ignored request and stable capture:** during a transfer, pulse `send` and change `data_in` to 16'h1234.
   - Transmitted bytes are unchanged.
   - No second transfer starts; `busy` stays 1 until `done`.
5. **Back-to-back:** hold `send`=1 across two transfers.
   - Exactly one cycle with `tx`=1 and `busy`=0 between transfers; the second start bit begins on the edge after `done`.
6. **Reset mid-transfer:** assert `rst` mid data bit while `tx`=0.
   - `tx`=1, `busy`=0, `done`=0 asynchronously.
   - After release, a new `send` starts a clean frame from byte 0.
